// File: rtl/dmem_write_buffer_pkg.sv
// Shared types for the data-memory posted-store buffer.
// Entry fields are sized at the package widths; narrower module widths use the low bits.
package dmem_wb_pkg;

  localparam int unsigned WB_DEPTH_DEFAULT = 4;
  localparam int unsigned WB_ADDR_W        = 32;
  localparam int unsigned WB_DATA_W        = 32;

  typedef struct packed {
    logic                   valid;
    logic [WB_ADDR_W-1:2]   addr;
    logic [WB_DATA_W-1:0]   data;
  } wb_entry_t;

  typedef enum logic {
    WB_RUN,
    WB_FLUSH
  } wb_state_t;

endpackage

// File: rtl/dmem_write_buffer_addr_match.sv
// Word-address lookup across the buffered stores.
// Reports whether any valid entry matches and which matching entry is youngest.
module wb_addr_match
  import dmem_wb_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]     valid,
  input  logic [WB_ADDR_W-1:2] tag [DEPTH],
  input  logic [PW-1:0]        head,
  input  logic [WB_ADDR_W-1:2] addr,
  output logic                 hit,
  output logic [PW-1:0]        idx
);

  logic [PW-1:0] slot;

  // Walk oldest (head) to youngest; a later match overwrites, so idx ends on the youngest hit.
  always_comb begin
    hit  = 1'b0;
    idx  = head;
    slot = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (valid[slot] && (tag[slot] == addr)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer between the MEM stage and single-port dmem.
// Stores are queued and retired in idle port cycles; loads own the port.
// Optional feature macro: WB_FWD_EN (forward youngest matching store data to loads).
module dmem_write_buffer
  import dmem_wb_pkg::*;
#(
  parameter int unsigned DEPTH  = WB_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W = WB_ADDR_W,
  parameter int unsigned DATA_W = WB_DATA_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic                       cpu_re,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_stall,
  input  logic                       flush_req,
  output logic                       flush_done,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ready,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0] wb_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  wb_entry_t            ents [DEPTH];
  wb_entry_t            new_ent;
  wb_entry_t            head_ent;
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count;
  wb_state_t            state, state_nx;
  logic [DEPTH-1:0]     ent_valid;
  logic [WB_ADDR_W-1:2] ent_tag [DEPTH];
  logic [WB_ADDR_W-1:2] lk_addr;
  logic                 hit;
  logic [PW-1:0]        hit_idx;
  logic                 ld, push, pop, empty, full;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign ld       = cpu_re & ~cpu_we;
  assign head_ent = ents[head];
  assign wb_count = count;

  // Build the incoming entry and the lookup key at package width.
  always_comb begin
    new_ent                  = '0;
    new_ent.valid            = 1'b1;
    new_ent.addr[ADDR_W-1:2] = cpu_addr[ADDR_W-1:2];
    new_ent.data[DATA_W-1:0] = cpu_wdata;
    lk_addr                  = '0;
    lk_addr[ADDR_W-1:2]      = cpu_addr[ADDR_W-1:2];
  end

  // Tag view of the entry array for the matcher.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ents[i].valid;
      ent_tag[i]   = ents[i].addr;
    end
  end

  wb_addr_match #(.DEPTH(DEPTH)) u_match (
    .valid (ent_valid),
    .tag   (ent_tag),
    .head  (head),
    .addr  (lk_addr),
    .hit   (hit),
    .idx   (hit_idx)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= WB_RUN;
    else        state <= state_nx;
  end

  // Next state, stall and drain decision. Fullness uses the registered count,
  // so a same-cycle drain never unblocks a stalled store.
  always_comb begin
    state_nx   = state;
    cpu_stall  = 1'b0;
    pop        = 1'b0;
    flush_done = 1'b0;
    unique case (state)
      WB_RUN: begin
        if (flush_req) state_nx = WB_FLUSH;
        if (cpu_we) begin
          cpu_stall = full;
          pop       = ~empty & mem_ready;
        end else if (ld) begin
`ifdef WB_FWD_EN
          cpu_stall = 1'b0;
          pop       = 1'b0;
`else
          // The load keeps the port, so a hit would never retire; force the drain instead.
          cpu_stall = hit;
          pop       = hit & mem_ready;
`endif
        end else begin
          pop = ~empty & mem_ready;
        end
      end
      WB_FLUSH: begin
        cpu_stall = cpu_we | cpu_re;
        pop       = ~empty & mem_ready;
        if (empty) begin
          state_nx   = WB_RUN;
          flush_done = 1'b1;
        end
      end
      default: state_nx = WB_RUN;
    endcase
  end

  assign push = cpu_we & ~cpu_stall;

  // Port mux: a retiring store drives the port, otherwise the MEM-stage address.
  always_comb begin
    mem_we    = pop;
    mem_addr  = pop ? {head_ent.addr[ADDR_W-1:2], 2'b00} : cpu_addr;
    mem_wdata = head_ent.data[DATA_W-1:0];
`ifdef WB_FWD_EN
    cpu_rdata = (ld && hit) ? ents[hit_idx].data[DATA_W-1:0] : mem_rdata;
`else
    cpu_rdata = mem_rdata;
`endif
  end

  // Entry storage, pointers and occupancy. Push and pop never target the same
  // slot: head==tail only when empty (no pop) or full (push stalled).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ents[i] <= '0;
    end else begin
      if (push) begin
        ents[tail] <= new_ent;
        tail       <= tail + PW'(1);
      end
      if (pop) begin
        ents[head].valid <= 1'b0;
        head             <= head + PW'(1);
      end
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Simultaneous store and load from the MEM stage is not a legal request.
  a_no_we_re: assert property (@(posedge clk) disable iff (!reset) !(cpu_we && cpu_re));

  // A reported hit must point at an occupied entry.
  a_hit_valid: assert property (@(posedge clk) disable iff (!reset) hit |-> ent_valid[hit_idx]);

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: vector table plus flush / reset sequences.
module tb_dmem_write_buffer;

  logic        clk, reset;
  logic        cpu_we, cpu_re, flush_req, flush_done;
  logic        cpu_stall, mem_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  wb_count;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .wb_count   (wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dmem model: word-addressed, cleared while mem_clr is high.
  logic        mem_clr;
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[9:2]];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic re, input logic fl, input logic rdy,
                       input logic [31:0] a, input logic [31:0] d);
    cpu_we    = we;
    cpu_re    = re;
    flush_req = fl;
    mem_ready = rdy;
    cpu_addr  = a;
    cpu_wdata = d;
  endtask

  typedef struct {
    logic        we, re, rdy;
    logic [31:0] addr, wdata;
    logic        e_stall, e_mwe;
    logic [2:0]  e_cnt;
    logic        ck_ma;
    logic [31:0] e_maddr, e_mwdata;
    logic        ck_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic we, input logic re, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic rdy,
                              input logic e_stall, input logic e_mwe, input logic [2:0] e_cnt,
                              input logic ck_ma, input logic [31:0] e_maddr,
                              input logic [31:0] e_mwdata,
                              input logic ck_rd, input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.re = re; v.addr = addr; v.wdata = wdata; v.rdy = rdy;
    v.e_stall = e_stall; v.e_mwe = e_mwe; v.e_cnt = e_cnt;
    v.ck_ma = ck_ma; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
    v.ck_rd = ck_rd; v.e_rdata = e_rdata;
    vq.push_back(v);
  endfunction

  int          nwr;
  logic [31:0] exp_wa [3];
  logic        done_seen;

  initial begin
    // two stores, port idle: each drains the cycle after its push
    add(1,0,'h10,'hAA,1, 0,0,0, 0,0,0,         0,0);
    add(1,0,'h14,'hBB,1, 0,1,1, 1,'h10,'hAA,   0,0);
    add(0,0,0,0,1,       0,1,1, 1,'h14,'hBB,   0,0);
    add(0,0,0,0,1,       0,0,0, 0,0,0,         0,0);
    // fill with mem_ready low, 5th store stalls until one cycle after the first pop
    add(1,0,'h40,1,0,    0,0,0, 0,0,0,         0,0);
    add(1,0,'h44,2,0,    0,0,1, 0,0,0,         0,0);
    add(1,0,'h48,3,0,    0,0,2, 0,0,0,         0,0);
    add(1,0,'h4C,4,0,    0,0,3, 0,0,0,         0,0);
    add(1,0,'h50,5,0,    1,0,4, 0,0,0,         0,0);
    add(1,0,'h50,5,1,    1,1,4, 1,'h40,1,      0,0);
    add(1,0,'h50,5,1,    0,1,3, 1,'h44,2,      0,0);
    add(0,0,0,0,1,       0,1,3, 1,'h48,3,      0,0);
    add(0,0,0,0,1,       0,1,2, 1,'h4C,4,      0,0);
    add(0,0,0,0,1,       0,1,1, 1,'h50,5,      0,0);
    add(0,0,0,0,1,       0,0,0, 0,0,0,         0,0);
    // store then load of the same word
    add(1,0,'h20,'h55,1, 0,0,0, 0,0,0,         0,0);
`ifdef WB_FWD_EN
    add(0,1,'h20,0,1,    0,0,1, 1,'h20,0,      1,'h55);
    add(0,1,'h20,0,1,    0,0,1, 1,'h20,0,      1,'h55);
    add(0,0,0,0,1,       0,1,1, 1,'h20,'h55,   0,0);
`else
    add(0,1,'h20,0,1,    1,1,1, 1,'h20,'h55,   0,0);
    add(0,1,'h20,0,1,    0,0,0, 1,'h20,0,      1,'h55);
    add(0,0,0,0,1,       0,0,0, 0,0,0,         0,0);
`endif
    // two stores to one word, then a load: youngest data must be observed
    add(1,0,'h30,1,0,    0,0,0, 0,0,0,         0,0);
    add(1,0,'h30,2,0,    0,0,1, 0,0,0,         0,0);
`ifdef WB_FWD_EN
    add(0,1,'h30,0,0,    0,0,2, 1,'h30,0,      1,2);
    add(0,1,'h30,0,1,    0,0,2, 1,'h30,0,      1,2);
    add(0,0,0,0,1,       0,1,2, 1,'h30,1,      0,0);
    add(0,0,0,0,1,       0,1,1, 1,'h30,2,      0,0);
    add(0,0,0,0,1,       0,0,0, 0,0,0,         0,0);
`else
    add(0,1,'h30,0,0,    1,0,2, 1,'h30,0,      0,0);
    add(0,1,'h30,0,1,    1,1,2, 1,'h30,1,      0,0);
    add(0,1,'h30,0,1,    1,1,1, 1,'h30,2,      0,0);
    add(0,1,'h30,0,1,    0,0,0, 1,'h30,0,      1,2);
    add(0,0,0,0,1,       0,0,0, 0,0,0,         0,0);
`endif

    // reset
    reset   = 1'b0;
    mem_clr = 1'b1;
    drive(0,0,0,1,0,0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset mem_we", mem_we, 0);
    chk("reset stall", cpu_stall, 0);
    chk("reset flush_done", flush_done, 0);
    chk("reset wb_count", wb_count, 0);
    @(negedge clk);
    reset   = 1'b1;
    mem_clr = 1'b0;

    // vector table
    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      drive(vq[k].we, vq[k].re, 1'b0, vq[k].rdy, vq[k].addr, vq[k].wdata);
      #1;
      chk($sformatf("v%0d stall", k), cpu_stall, vq[k].e_stall);
      chk($sformatf("v%0d mem_we", k), mem_we, vq[k].e_mwe);
      chk($sformatf("v%0d wb_count", k), wb_count, vq[k].e_cnt);
      chk($sformatf("v%0d flush_done", k), flush_done, 0);
      if (vq[k].ck_ma) chk($sformatf("v%0d mem_addr", k), mem_addr, vq[k].e_maddr);
      if (vq[k].e_mwe) chk($sformatf("v%0d mem_wdata", k), mem_wdata, vq[k].e_mwdata);
      if (vq[k].ck_rd) chk($sformatf("v%0d cpu_rdata", k), cpu_rdata, vq[k].e_rdata);
    end

    // flush with three buffered entries
    @(negedge clk); drive(1,0,0,0,'h60,'hA);
    @(negedge clk); drive(1,0,0,0,'h64,'hB);
    @(negedge clk); drive(1,0,0,0,'h68,'hC);
    @(negedge clk); drive(0,0,1,0,0,0);
    #1;
    chk("flush pre count", wb_count, 3);
    chk("flush pre stall", cpu_stall, 0);
    chk("flush pre done", flush_done, 0);
    exp_wa[0] = 'h60; exp_wa[1] = 'h64; exp_wa[2] = 'h68;
    nwr = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 12 && !done_seen; c++) begin
      @(negedge clk);
      drive(1,0,0,1,'h70,'hD);
      #1;
      chk($sformatf("flush c%0d stall", c), cpu_stall, 1);
      if (flush_done) begin
        done_seen = 1'b1;
        chk("flush done count", wb_count, 0);
        chk("flush writes", nwr, 3);
      end else if (mem_we) begin
        if (nwr < 3) chk($sformatf("flush w%0d addr", nwr), mem_addr, exp_wa[nwr]);
        nwr++;
      end
    end
    chk("flush done seen", done_seen, 1);
    @(negedge clk); drive(1,0,0,1,'h70,'hD);
    #1;
    chk("post flush stall", cpu_stall, 0);
    chk("post flush done", flush_done, 0);
    @(negedge clk); drive(0,0,0,1,0,0);
    #1;
    chk("post flush count", wb_count, 1);
    chk("post flush mem_we", mem_we, 1);
    chk("post flush mem_addr", mem_addr, 'h70);
    @(negedge clk);
    #1;
    chk("mem 0x60", mem['h60 >> 2], 'hA);
    chk("mem 0x64", mem['h64 >> 2], 'hB);
    chk("mem 0x68", mem['h68 >> 2], 'hC);
    chk("mem 0x70", mem['h70 >> 2], 'hD);

    // flush while empty: done the next cycle, single pulse
    @(negedge clk); drive(0,0,1,1,0,0);
    #1;
    chk("empty flush c0 done", flush_done, 0);
    @(negedge clk); drive(0,0,0,1,0,0);
    #1;
    chk("empty flush c1 done", flush_done, 1);
    @(negedge clk);
    #1;
    chk("empty flush c2 done", flush_done, 0);

    // reset asserted with two stores pending
    @(negedge clk); drive(1,0,0,0,'h80,7);
    @(negedge clk); drive(1,0,0,0,'h84,8);
    @(negedge clk); drive(0,0,0,1,0,0);
    #1;
    chk("pre reset count", wb_count, 2);
    chk("pre reset mem_we", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid reset mem_we", mem_we, 0);
    chk("mid reset count", wb_count, 0);
    nwr = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (mem_we) nwr++;
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      if (mem_we) nwr++;
    end
    chk("writes after reset", nwr, 0);
    chk("post reset count", wb_count, 0);
    chk("mem 0x80 untouched", mem['h80 >> 2], 0);
    chk("mem 0x84 untouched", mem['h84 >> 2], 0);
    @(negedge clk); drive(1,0,0,1,'h88,9);
    #1;
    chk("reset store stall", cpu_stall, 0);
    @(negedge clk); drive(0,0,0,1,0,0);
    #1;
    chk("reset store count", wb_count, 1);
    chk("reset store mem_we", mem_we, 1);
    chk("reset store addr", mem_addr, 'h88);
    chk("reset store data", mem_wdata, 9);
    @(negedge clk);
    #1;
    chk("reset store drained", wb_count, 0);
    chk("mem 0x88", mem['h88 >> 2], 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
